// File: rtl/gate_unit_arbiter.sv
// Round-robin arbiter sharing one decoder-based bitwise gate unit between two requesters.
// Accept->EVAL->RESP (response 2 cycles after accept); GATE_ARB_STATS_EN adds grant counters.
module gate_unit_arbiter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [2:0]   req0_op,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [2:0]   req1_op,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [W-1:0] rsp_data,
   output logic         rsp_id,
   output logic         rsp_err,
   output logic         busy
`ifdef GATE_ARB_STATS_EN
   ,
   output logic [15:0]  gnt0_cnt,
   output logic [15:0]  gnt1_cnt
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_EVAL, S_RESP} state_t;

   state_t         state_q, state_d;
   logic           prio_q, prio_d;
   logic [2:0]     op_q, op_d;
   logic [W-1:0]   a_q, a_d, b_q, b_d;
   logic           id_q, id_d;
   logic           rsp_valid_q, rsp_valid_d;
   logic [W-1:0]   rsp_data_q, rsp_data_d;
   logic           rsp_id_q, rsp_id_d;
   logic           rsp_err_q, rsp_err_d;
   logic           busy_q, busy_d;
   logic           gnt0, gnt1;
   logic [W-1:0]   y0, y1, y2, y3, gate_res;

   // Grants are combinational so the winner sees ready in its request cycle.
   always_comb begin
      gnt0 = (state_q == S_IDLE) && !rst && req0_valid && (!req1_valid || !prio_q);
      gnt1 = (state_q == S_IDLE) && !rst && req1_valid && (!req0_valid ||  prio_q);
   end

   always_comb begin
      y0 = ~a_q & ~b_q;
      y1 = ~a_q &  b_q;
      y2 =  a_q & ~b_q;
      y3 =  a_q &  b_q;
      gate_res = '0;
      case (op_q)
         3'd0:    gate_res = y3;
         3'd1:    gate_res = y1 | y2 | y3;
         3'd2:    gate_res = ~a_q;
         3'd3:    gate_res = y0;
         3'd4:    gate_res = ~y3;
         3'd5:    gate_res = y1 | y2;
         3'd6:    gate_res = y0 | y3;
         default: gate_res = '0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      prio_d      = prio_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      id_d        = id_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_id_d    = rsp_id_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         S_IDLE: begin
            if (gnt0 || gnt1) begin
               state_d = S_EVAL;
               id_d    = gnt1;
               prio_d  = gnt0;
               op_d    = gnt1 ? req1_op : req0_op;
               a_d     = gnt1 ? req1_a  : req0_a;
               b_d     = gnt1 ? req1_b  : req0_b;
            end
         end
         S_EVAL: begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = gate_res;
            rsp_id_d    = id_q;
            rsp_err_d   = (op_q == 3'd7);
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         prio_q      <= 1'b0;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         id_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_id_q    <= 1'b0;
         rsp_err_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         prio_q      <= prio_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         id_q        <= id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_id_q    <= rsp_id_d;
         rsp_err_q   <= rsp_err_d;
         busy_q      <= busy_d;
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_err    = rsp_err_q;
   assign busy       = busy_q;

`ifdef GATE_ARB_STATS_EN
   logic [15:0] gnt0_cnt_q, gnt0_cnt_d, gnt1_cnt_q, gnt1_cnt_d;

   // Saturating counters so long runs never wrap back to small values.
   always_comb begin
      gnt0_cnt_d = gnt0_cnt_q;
      gnt1_cnt_d = gnt1_cnt_q;
      if (gnt0 && gnt0_cnt_q != 16'hFFFF) gnt0_cnt_d = gnt0_cnt_q + 16'd1;
      if (gnt1 && gnt1_cnt_q != 16'hFFFF) gnt1_cnt_d = gnt1_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt0_cnt_q <= '0;
         gnt1_cnt_q <= '0;
      end else begin
         gnt0_cnt_q <= gnt0_cnt_d;
         gnt1_cnt_q <= gnt1_cnt_d;
      end
   end

   assign gnt0_cnt = gnt0_cnt_q;
   assign gnt1_cnt = gnt1_cnt_q;
`endif

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Directed and randomized bench for gate_unit_arbiter against a truth-table reference model.
module tb_gate_unit_arbiter;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         req0_valid, req1_valid, rsp_ready;
   logic         req0_ready, req1_ready;
   logic [2:0]   req0_op, req1_op;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic         rsp_valid, rsp_id, rsp_err, busy;
   logic [W-1:0] rsp_data;
`ifdef GATE_ARB_STATS_EN
   logic [15:0]  gnt0_cnt, gnt1_cnt;
`endif

   int errors = 0;
   int checks = 0;
   int m_prio = 0;

   gate_unit_arbiter #(.W(W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy)
`ifdef GATE_ARB_STATS_EN
      , .gnt0_cnt(gnt0_cnt), .gnt1_cnt(gnt1_cnt)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [W-1:0] ref_gate(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      case (op)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return ~a;
         3'd3:    return ~(a | b);
         3'd4:    return ~(a & b);
         3'd5:    return a ^ b;
         3'd6:    return ~(a ^ b);
         default: return '0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Returns at negedge+1 of the accept cycle; who=-1 if nobody was granted in time.
   task automatic wait_accept(output int who);
      who = -1;
      for (int i = 0; i < 20 && who < 0; i++) begin
         #1;
         if (req0_ready) who = 0;
         else if (req1_ready) who = 1;
         else @(negedge clk);
      end
      chk("accept_seen", 32'(who >= 0), 1);
      chk("one_ready", 32'(req0_ready & req1_ready), 0);
   endtask

   task automatic drive(input int id, input logic v, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      if (id == 0) begin req0_valid = v; req0_op = op; req0_a = a; req0_b = b; end
      else         begin req1_valid = v; req1_op = op; req1_a = a; req1_b = b; end
   endtask

   // Single-requester transaction with rsp_ready high; starts and ends on a negedge.
   task automatic issue(input int id, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int who;
      drive(id, 1'b1, op, a, b);
      wait_accept(who);
      chk("grant_id", who, id);
      m_prio = 1 - id;
      @(negedge clk);
      drive(id, 1'b0, op, a, b);
      #1;
      chk("eval_valid", rsp_valid, 0);
      chk("eval_busy", busy, 1);
      chk("eval_ready", 32'(req0_ready | req1_ready), 0);
      @(negedge clk); #1;
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_data", rsp_data, ref_gate(op, a, b));
      chk("rsp_id", rsp_id, id);
      chk("rsp_err", rsp_err, 32'(op == 3'd7));
      @(negedge clk); #1;
      chk("idle_busy", busy, 0);
      chk("idle_valid", rsp_valid, 0);
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_prio = 0;
   endtask

   initial begin
      logic [W-1:0] sweep_tab [8];
      logic [W-1:0] pa [2];
      logic [W-1:0] pb [2];
      logic [2:0]   po [2];
      logic [W-1:0] bp_exp;
      int           who;

      sweep_tab = '{4'b1000, 4'b1110, 4'b0011, 4'b0001, 4'b0111, 4'b0110, 4'b1001, 4'b0000};
      rst = 1'b1;
      rsp_ready = 1'b1;
      drive(0, 1'b0, 3'd0, '0, '0);
      drive(1, 1'b0, 3'd0, '0, '0);
      #1;
      chk("rst_valid", rsp_valid, 0);
      chk("rst_data", rsp_data, 0);
      chk("rst_id", rsp_id, 0);
      chk("rst_err", rsp_err, 0);
      chk("rst_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;

      // Single XOR op with exact spec value
      issue(0, 3'd5, 4'b1100, 4'b1010);
      chk("xor_exact", rsp_data, 4'b0110);

      // Opcode sweep against the published truth table
      for (int op = 0; op < 8; op++) begin
         issue(op % 2, 3'(op), 4'b1100, 4'b1010);
         chk("sweep_data", rsp_data, sweep_tab[op]);
         chk("sweep_err", rsp_err, 32'(op == 7));
      end

      // Randomized single-requester traffic
      for (int k = 0; k < 20; k++)
         issue(int'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), W'($urandom), W'($urandom));

      // Round robin with both requesters continuously valid, from reset
      reset_pulse();
      for (int r = 0; r < 2; r++) begin
         po[r] = 3'($urandom_range(0, 7)); pa[r] = W'($urandom); pb[r] = W'($urandom);
         drive(r, 1'b1, po[r], pa[r], pb[r]);
      end
      for (int k = 0; k < 4; k++) begin
         wait_accept(who);
         chk("rr_model", who, m_prio);
         chk("rr_seq", who, k % 2);
         if (who < 0) who = 0;
         m_prio = 1 - who;
         bp_exp = ref_gate(po[who], pa[who], pb[who]);
         @(negedge clk);
         po[who] = 3'($urandom_range(0, 7)); pa[who] = W'($urandom); pb[who] = W'($urandom);
         drive(who, 1'b1, po[who], pa[who], pb[who]);
         #1;
         chk("rr_eval_ready", 32'(req0_ready | req1_ready), 0);
         @(negedge clk); #1;
         chk("rr_resp_ready", 32'(req0_ready | req1_ready), 0);
         chk("rr_id", rsp_id, who);
         chk("rr_data", rsp_data, bp_exp);
         @(negedge clk);
      end
      drive(0, 1'b0, 3'd0, '0, '0);
      drive(1, 1'b0, 3'd0, '0, '0);

      // Backpressure: 10 stalled cycles in RESP while req1 waits
      @(negedge clk);
      rsp_ready = 1'b0;
      po[0] = 3'd4; pa[0] = W'($urandom); pb[0] = W'($urandom);
      bp_exp = ref_gate(po[0], pa[0], pb[0]);
      drive(0, 1'b1, po[0], pa[0], pb[0]);
      wait_accept(who);
      chk("bp_grant0", who, 0);
      m_prio = 1;
      @(negedge clk);
      drive(0, 1'b0, 3'd0, '0, '0);
      po[1] = 3'd6; pa[1] = W'($urandom); pb[1] = W'($urandom);
      drive(1, 1'b1, po[1], pa[1], pb[1]);
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("bp_valid", rsp_valid, 1);
         chk("bp_data", rsp_data, bp_exp);
         chk("bp_req1_ready", req1_ready, 0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_hs_ready", req1_ready, 0);
      @(negedge clk); #1;
      chk("bp_first_idle", req1_ready, 1);
      m_prio = 0;
      @(negedge clk);
      drive(1, 1'b0, 3'd0, '0, '0);
      @(negedge clk); #1;
      chk("bp_r1_valid", rsp_valid, 1);
      chk("bp_r1_id", rsp_id, 1);
      chk("bp_r1_data", rsp_data, ref_gate(po[1], pa[1], pb[1]));
      @(negedge clk);

      // Reset asserted mid-RESP holding data 4'hA
      rsp_ready = 1'b0;
      drive(0, 1'b1, 3'd0, 4'hA, 4'hA);
      wait_accept(who);
      @(negedge clk);
      drive(0, 1'b0, 3'd0, '0, '0);
      @(negedge clk); #1;
      chk("pre_rst_valid", rsp_valid, 1);
      chk("pre_rst_data", rsp_data, 4'hA);
      req1_valid = 1'b1;
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", rsp_valid, 0);
      chk("mid_rst_data", rsp_data, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ready", 32'(req0_ready | req1_ready), 0);
      @(negedge clk);
      req1_valid = 1'b0;
      rst = 1'b0;
      m_prio = 0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         chk("post_rst_quiet", 32'(rsp_valid | busy), 0);
      end

`ifdef GATE_ARB_STATS_EN
      reset_pulse();
      chk("cnt0_reset", gnt0_cnt, 0);
      chk("cnt1_reset", gnt1_cnt, 0);
      for (int k = 0; k < 5; k++)
         issue(k < 3 ? 0 : 1, 3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
      chk("cnt0", gnt0_cnt, 3);
      chk("cnt1", gnt1_cnt, 2);
      force dut.gnt0_cnt_q = 16'hFFFF;
      @(negedge clk);
      release dut.gnt0_cnt_q;
      issue(0, 3'd1, 4'h3, 4'h5);
      chk("cnt0_sat", gnt0_cnt, 16'hFFFF);
      chk("cnt1_hold", gnt1_cnt, 2);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gate_unit_arbiter.md
# gate_unit_arbiter

Round-robin arbiter and sequencer that shares one decoder-based logic-gate evaluation unit between two requesters. Each requester submits an opcode and two W-bit operands over a valid/ready handshake. The block grants one request at a time, evaluates it bitwise through an internal 2-to-4 decoder per bit, and returns the registered result with the requester ID over a valid/ready response channel. It sits between the gate datapath and its two client blocks.

## Interface
- W, 4, operand/result width in bits (1..32)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req0_valid  in  1  requester 0 request valid
- req0_ready  out  1  requester 0 request accepted this cycle
- req0_op  in  3  requester 0 opcode
- req0_a, req0_b  in  W  requester 0 operands
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_data  out  W  bitwise result
- rsp_id  out  1  requester that issued the request
- rsp_err  out  1  illegal opcode flag
- busy  out  1  high whenever state is not IDLE
- gnt0_cnt, gnt1_cnt  out  16  grant counters; present only with GATE_ARB_STATS_EN

## Operation
- Per-bit decoder: y0=~a&~b, y1=~a&b, y2=a&~b, y3=a&b. All gate results are formed from y terms only, except NOT.
- Opcodes:
  - 0 AND = y3
  - 1 OR = y1|y2|y3
  - 2 NOT = ~a (b ignored)
  - 3 NOR = y0
  - 4 NAND = ~y3
  - 5 XOR = y1|y2
  - 6 XNOR = y0|y3
  - 7 illegal: rsp_data=0, rsp_err=1
- FSM states: IDLE, EVAL, RESP.
- IDLE:
  - If any reqN_valid is high, grant one requester, assert its reqN_ready combinationally in the same cycle, capture op/a/b/id, and go to EVAL.
  - If neither is valid, stay in IDLE.
- Arbitration:
  - Single valid requester: it is granted.
  - Both valid: the requester selected by priority pointer `prio` wins.
  - After every grant, `prio` moves to the non-granted requester.
  - `prio` resets to 0.
- EVAL: compute the result from the captured operands, register it into rsp_data/rsp_err/rsp_id, and go to RESP.
- RESP:
  - rsp_valid=1. rsp_data, rsp_id and rsp_err are held stable until rsp_valid && rsp_ready.
  - On that handshake, go to IDLE.
- reqN_ready is never high outside IDLE. At most one reqN_ready is high in any cycle.
- Requests arriving while busy wait; a requester must hold valid and its payload until ready.

## Timing
- Reset values: state=IDLE, prio=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, busy=0, req0_ready=0, req1_ready=0 (while rst high), gnt counters=0.
- Accept in cycle N, EVAL in N+1, rsp_valid rises at N+2.
- With rsp_ready held high: handshake at N+2, IDLE at N+3, next accept possible at N+3. Peak throughput is one request per 3 cycles.
- Backpressure: rsp_ready low stalls in RESP indefinitely with outputs frozen.
- Simultaneous events:
  - Valid requests arriving during the RESP handshake cycle are not accepted until the following IDLE cycle.
  - Both requesters held valid continuously are granted alternately: 0,1,0,1 from reset.
- Reset mid-operation, asserted at any state: outputs return to reset values immediately. The captured request is dropped and no response is produced.

## Configuration
- GATE_ARB_STATS_EN defined:
  - gnt0_cnt and gnt1_cnt exist.
  - Each increments by 1 on the clock edge ending its requester's accept cycle.
  - Each saturates at 16'hFFFF and resets to 0.
- GATE_ARB_STATS_EN undefined: the counter ports and logic are absent. All other behaviour is identical.

## Test plan
- Reset and idle:
  - Stimulus: assert rst mid-RESP, with rsp_valid=1 and data 4'hA.
  - Required: rsp_valid=0, rsp_data=0 and busy=0 immediately; no response after rst is released.
- Single op:
  - Stimulus: W=4, req0 op=5 (XOR), a=4'b1100, b=4'b1010, rsp_ready=1.
  - Required: rsp_valid 2 cycles after accept, rsp_data=4'b0110, rsp_id=0, rsp_err=0.
- Full opcode sweep:
  - Stimulus: a=4'b1100, b=4'b1010 for each opcode.
  - Required: AND 1000, OR 1110, NOT 0011, NOR 0001, NAND 0111, XOR 0110, XNOR 1001; op=7 gives 0000 with rsp_err=1.
- Round-robin:
  - Stimulus: both requesters held valid for 4 requests.
  - Required: rsp_id sequence 0,1,0,1; never both reqN_ready high in one cycle.
- Backpressure:
  - Stimulus: hold rsp_ready=0 for 10 cycles in RESP, with req1 valid throughout.
  - Required: rsp_data stable, req1_ready=0 throughout; req1 accepted in the first IDLE cycle after the handshake.
- Stats (GATE_ARB_STATS_EN):
  - Stimulus: 3 grants to req0 and 2 to req1.
  - Required: gnt0_cnt=3, gnt1_cnt=2; a counter preloaded (forced) to 16'hFFFF stays 16'hFFFF after a further grant.
